// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: control state encodings and count limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam int         MIN_MAX = 99;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// One-second timebase: counts clk cycles while running, holds while paused,
// and is forced back to zero by clr (idle or clear).
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // Next prescaler value: clear wins, otherwise wrap at CLK_DIV-1 while running.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (run) begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign tick = run && (pcnt_q == PCNT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, run/pause/clear FSM and the
// 0-59 seconds counter feeding the minutes counter.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | cleared, prescaler held at 0, not counting
// ST_RUNNING | counting; enable/running high
// ST_PAUSED  | counting frozen, prescaler fraction preserved
// 2'b11      | illegal, returns to ST_IDLE
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  output logic       enable,
  output logic       sw_clear,
  output logic       sec_rollover,
  output logic [5:0] seconds,
  output logic       running
);

  state_e     state_q, state_d;
  logic       ss_q, clr_q;
  logic       ss_edge, clr_edge;
  logic       sw_clear_q, sw_clear_d;
  logic       sec_rollover_q, sec_rollover_d;
  logic [5:0] seconds_q, seconds_d;
  logic       tick;
  logic       is_running;
  logic       pcnt_clr;

  // Buttons reset to 1 so a button held through reset is not seen as a press.
  assign ss_edge  = start_stop_btn & ~ss_q;
  assign clr_edge = clear_btn & ~clr_q;

  assign is_running = (state_q == ST_RUNNING);
  assign pcnt_clr   = clr_edge || (state_q == ST_IDLE);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (is_running),
    .clr  (pcnt_clr),
    .tick (tick)
  );

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q  <= 1'b1;
      clr_q <= 1'b1;
    end else begin
      ss_q  <= start_stop_btn;
      clr_q <= clear_btn;
    end
  end

  // Next state: clear overrides start/stop in the same cycle.
  always_comb begin
    state_d    = state_q;
    sw_clear_d = clr_edge;
    if (clr_edge) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (ss_edge) state_d = ST_RUNNING;
        ST_RUNNING: if (ss_edge) state_d = ST_PAUSED;
        ST_PAUSED:  if (ss_edge) state_d = ST_RUNNING;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Seconds update; a tick in the cycle that leaves RUNNING still counts,
  // but a clear in that cycle suppresses both the increment and the rollover.
  always_comb begin
    seconds_d      = seconds_q;
    sec_rollover_d = 1'b0;
    if (clr_edge) begin
      seconds_d = '0;
    end else if (tick) begin
      if (seconds_q >= SEC_MAX) begin
        seconds_d      = '0;
        sec_rollover_d = 1'b1;
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end
  end

  // State, seconds and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      seconds_q      <= '0;
      sw_clear_q     <= 1'b0;
      sec_rollover_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      seconds_q      <= seconds_d;
      sw_clear_q     <= sw_clear_d;
      sec_rollover_q <= sec_rollover_d;
    end
  end

  assign enable       = is_running;
  assign running      = is_running;
  assign sw_clear     = sw_clear_q;
  assign sec_rollover = sec_rollover_q;
  assign seconds      = seconds_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_DIV = 4. The reference model tracks the
// total number of clock cycles spent running since the last clear and derives
// the seconds display and rollover pulse from that count arithmetically.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       start_stop_btn;
  logic       clear_btn;
  logic       enable;
  logic       sw_clear;
  logic       sec_rollover;
  logic [5:0] seconds;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mmode_e;
  mmode_e m_mode;
  int     m_run;
  bit     m_roll, m_swc, m_ss_prev, m_clr_prev;

  stopwatch_ctrl #(.CLK_DIV(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_stop_btn (start_stop_btn),
    .clear_btn      (clear_btn),
    .enable         (enable),
    .sw_clear       (sw_clear),
    .sec_rollover   (sec_rollover),
    .seconds        (seconds),
    .running        (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached without finishing");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] exp_sec();
    return 6'((m_run / D) % 60);
  endfunction

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_run      = 0;
    m_roll     = 1'b0;
    m_swc      = 1'b0;
    m_ss_prev  = 1'b1;
    m_clr_prev = 1'b1;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    bit ss_e, clr_e, was_run;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      ss_e       = start_stop_btn && !m_ss_prev;
      clr_e      = clear_btn && !m_clr_prev;
      was_run    = (m_mode == M_RUN);
      m_ss_prev  = start_stop_btn;
      m_clr_prev = clear_btn;
      m_swc      = clr_e;
      m_roll     = 1'b0;
      if (clr_e) begin
        m_mode = M_IDLE;
        m_run  = 0;
      end else begin
        if (was_run) begin
          m_run  = m_run + 1;
          m_roll = ((m_run % (60 * D)) == 0);
        end
        if (ss_e) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end
    end
    #1;
  endtask

  task automatic do_clear();
    clear_btn = 1'b1;
    step();
    clear_btn = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start_stop_btn = 1'b0; clear_btn = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({enable, running, sw_clear, sec_rollover, seconds} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required %b",
               {enable, running, sw_clear, sec_rollover, seconds}, 10'b0);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({enable, sw_clear, seconds} !== 8'b0) begin
      n_err++;
      $display("FAIL after_release: got %b required %b", {enable, sw_clear, seconds}, 8'b0);
    end
  endtask

  task automatic test_held_through_reset();
    rst = 1'b1; start_stop_btn = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (enable !== 1'b0) begin
      n_err++;
      $display("FAIL held_btn_no_start: enable got %b required 0", enable);
    end
    start_stop_btn = 1'b0;
    step();
    start_stop_btn = 1'b1;
    step();
    n_cmp++;
    if ({enable, running} !== 2'b11) begin
      n_err++;
      $display("FAIL press_after_release: enable/running got %b required 11", {enable, running});
    end
    start_stop_btn = 1'b0;
    step();
    do_clear();
  endtask

  task automatic test_run_rollover();
    int roll_cnt = 0;
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    for (int i = 0; i < 240; i++) begin
      step();
      n_cmp++;
      if ({sec_rollover, seconds} !== {m_roll, exp_sec()}) begin
        n_err++;
        $display("FAIL run_seconds cycle %0d: roll/sec got %b/%0d required %b/%0d",
                 i, sec_rollover, seconds, m_roll, exp_sec());
      end
      if (sec_rollover === 1'b1) begin
        roll_cnt++;
        n_cmp++;
        if ({enable, seconds} !== {1'b1, 6'd0}) begin
          n_err++;
          $display("FAIL rollover_context: enable/sec got %b/%0d required 1/0", enable, seconds);
        end
      end
    end
    n_cmp++;
    if (roll_cnt != 1 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL rollover_count: pulses %0d seconds %0d required 1 and 0", roll_cnt, seconds);
    end
  endtask

  task automatic test_pause_resume();
    do_clear();
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    step();
    start_stop_btn = 1'b1;
    step();
    n_cmp++;
    if (enable !== 1'b0) begin
      n_err++;
      $display("FAIL pause_enable: got %b required 0", enable);
    end
    start_stop_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({enable, seconds} !== 7'd0) begin
        n_err++;
        $display("FAIL paused_hold cycle %0d: enable/sec got %b/%0d required 0/0", i, enable, seconds);
      end
    end
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    n_cmp++;
    if (enable !== 1'b1) begin
      n_err++;
      $display("FAIL resume_enable: got %b required 1", enable);
    end
    step();
    n_cmp++;
    if (seconds !== 6'd0) begin
      n_err++;
      $display("FAIL resume_early: seconds got %0d required 0", seconds);
    end
    step();
    n_cmp++;
    if (seconds !== 6'd1 || seconds !== exp_sec()) begin
      n_err++;
      $display("FAIL resume_tick: seconds got %0d required 1 (model %0d)", seconds, exp_sec());
    end
  endtask

  task automatic test_simultaneous();
    do_clear();
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    for (int k = 0; k < 200 && seconds !== 6'd23; k++) step();
    n_cmp++;
    if ({enable, seconds} !== {1'b1, 6'd23}) begin
      n_err++;
      $display("FAIL reach_23: enable/sec got %b/%0d required 1/23", enable, seconds);
    end
    start_stop_btn = 1'b1; clear_btn = 1'b1;
    step();
    start_stop_btn = 1'b0; clear_btn = 1'b0;
    n_cmp++;
    if ({sw_clear, enable, running, seconds} !== {3'b100, 6'd0}) begin
      n_err++;
      $display("FAIL both_buttons: clr/en/run/sec got %b%b%b/%0d required 100/0",
               sw_clear, enable, running, seconds);
    end
    step();
    n_cmp++;
    if ({sw_clear, enable, seconds} !== 8'd0) begin
      n_err++;
      $display("FAIL both_buttons_after: clr/en/sec got %b%b/%0d required 00/0", sw_clear, enable, seconds);
    end
  endtask

  task automatic test_clear_on_tick();
    do_clear();
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    for (int k = 0; k < 400 && !(exp_sec() == 6'd59 && (m_run % D) == D - 1); k++) step();
    n_cmp++;
    if (seconds !== 6'd59) begin
      n_err++;
      $display("FAIL reach_59: seconds got %0d required 59", seconds);
    end
    clear_btn = 1'b1;
    step();
    clear_btn = 1'b0;
    n_cmp++;
    if ({seconds, sec_rollover, sw_clear} !== {6'd0, 2'b01}) begin
      n_err++;
      $display("FAIL clear_on_tick: sec/roll/clr got %0d/%b/%b required 0/0/1",
               seconds, sec_rollover, sw_clear);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if ({sec_rollover, sw_clear, seconds} !== 8'd0) begin
        n_err++;
        $display("FAIL clear_on_tick_after cycle %0d: roll/clr/sec got %b/%b/%0d required 0/0/0",
                 i, sec_rollover, sw_clear, seconds);
      end
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    for (int k = 0; k < 300 && seconds !== 6'd37; k++) step();
    n_cmp++;
    if (seconds !== 6'd37) begin
      n_err++;
      $display("FAIL reach_37: seconds got %0d required 37", seconds);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({enable, running, sw_clear, sec_rollover, seconds} !== 10'b0) begin
      n_err++;
      $display("FAIL async_reset: outputs got %b required %b",
               {enable, running, sw_clear, sec_rollover, seconds}, 10'b0);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({enable, sw_clear, seconds} !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset_idle: en/clr/sec got %b/%b/%0d required 0/0/0", enable, sw_clear, seconds);
    end
    start_stop_btn = 1'b1;
    step();
    start_stop_btn = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({enable, seconds} !== {1'b1, 6'd0}) begin
      n_err++;
      $display("FAIL post_reset_prescale: en/sec got %b/%0d required 1/0", enable, seconds);
    end
    step();
    n_cmp++;
    if (seconds !== 6'd1) begin
      n_err++;
      $display("FAIL post_reset_first_tick: seconds got %0d required 1", seconds);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_v;
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   start_stop_btn = ~start_stop_btn;
      if ($urandom_range(0, 299) == 0) clear_btn = ~clear_btn;
      step();
      exp_v = {m_mode == M_RUN, m_mode == M_RUN, m_swc, m_roll, exp_sec()};
      n_cmp++;
      if ({enable, running, sw_clear, sec_rollover, seconds} !== exp_v) begin
        n_err++;
        $display("FAIL random cycle %0d: en/run/clr/roll/sec got %b required %b",
                 i, {enable, running, sw_clear, sec_rollover, seconds}, exp_v);
      end
    end
    start_stop_btn = 1'b0;
    clear_btn = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_held_through_reset();
    test_run_rollover();
    test_pause_resume();
    test_simultaneous();
    test_clear_on_tick();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM and seconds timebase for the stopwatch. It turns debounced start/stop and clear buttons into run/pause/clear control and prescales `clk` into one-second ticks. It keeps the 0–59 seconds count and drives the minutes counter's `enable`, `reset` and `sec_rollover` inputs. The block sits between the button front-end and the minutes counter / display path.

## Interface
- `CLK_DIV`, default 50_000_000: `clk` cycles per second. Must be ≥ 2. Internal prescaler width is `$clog2(CLK_DIV)`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_stop_btn`  in  1  debounced level, synchronous to `clk`; each rising edge toggles run/pause.
- `clear_btn`  in  1  debounced level, synchronous to `clk`; each rising edge clears the stopwatch.
- `enable`  out  1  high while in RUNNING; goes to the minutes counter `enable`.
- `sw_clear`  out  1  one-cycle clear pulse; goes to the minutes counter `reset`.
- `sec_rollover`  out  1  one-cycle pulse when seconds wraps 59→0.
- `seconds`  out  6  current seconds, 0–59.
- `running`  out  1  status for the display; equal to `enable`.

## Operation
- Edge detect:
  - `ss_edge = start_stop_btn & ~ss_q`; `clr_edge = clear_btn & ~clr_q`.
  - `ss_q` and `clr_q` reset to 1, so a button held through reset does not fire.
- States: IDLE (2'b00), RUNNING (2'b01), PAUSED (2'b10). 2'b11 is illegal and recovers to IDLE.
- Transitions:
  - Any state with `clr_edge` → IDLE and pulse `sw_clear`. Clear has priority over `ss_edge` in the same cycle.
  - IDLE with `ss_edge` → RUNNING.
  - RUNNING with `ss_edge` → PAUSED.
  - PAUSED with `ss_edge` → RUNNING.
- Prescaler `pcnt`:
  - Counts 0..CLK_DIV-1 only in RUNNING; held in PAUSED.
  - Forced to 0 in IDLE and on clear.
  - `tick = RUNNING && pcnt == CLK_DIV-1`.
- Seconds:
  - On `tick`: if `seconds == 59`, seconds ← 0 and `sec_rollover` ← 1; otherwise seconds ← seconds + 1.
  - Held when there is no tick. Forced to 0 on clear.
- `sec_rollover` is registered and high for exactly one cycle, the first cycle in which `seconds == 0` after a wrap.
- `sw_clear` is registered and high for exactly one cycle after the clear edge.
  - In that cycle `enable == 0` and `sec_rollover == 0`.
  - This guarantees the minutes counter never sees clear and increment together.
- Leaving RUNNING in the same cycle as a tick still completes that tick (seconds update and rollover are taken).

## Timing
- Reset values: state IDLE; `enable`, `running`, `sw_clear`, `sec_rollover` = 0; `seconds` = 0; `pcnt` = 0; `ss_q`, `clr_q` = 1.
- Button latency: button high first sampled at edge N (edge detected in cycle N). The state change is visible after edge N+1, i.e. one cycle.
- `enable` is decoded from the state register, so it changes one cycle after the edge cycle.
- First tick after start: CLK_DIV cycles after entering RUNNING. A pause freezes `pcnt`, so the remaining fraction of the second is preserved across the pause.
- Rollover period while RUNNING: 60·CLK_DIV cycles. `sec_rollover` coincides with `enable == 1` unless a clear intervenes.
- Clear landing on a tick cycle: clear wins. Seconds goes to 0 and `sec_rollover` stays 0.
- Asserting `rst` mid-operation zeroes all outputs immediately, with no clock edge required.

## Structure
- Shared package `stopwatch_pkg`:
  - state encodings `ST_IDLE`, `ST_RUNNING`, `ST_PAUSED`
  - `SEC_MAX = 59`
  - `MIN_MAX = 99`, also consumed by the minutes counter
- Sub-module `tick_gen`:
  - parameter CLK_DIV; ports clk, rst, run, clr, tick
  - contains `pcnt`
- FSM, edge detection and the seconds counter live in the top module.

## Test plan
- Hold `start_stop_btn` = 1 through `rst` release → stays IDLE, `enable` = 0. Drop the button then raise it → `enable` = 1 one cycle later.
- CLK_DIV = 4: start and run 240 cycles → `seconds` steps every 4 cycles, 59→0 with `sec_rollover` high exactly 1 cycle and `enable` = 1.
- CLK_DIV = 4: pause when `pcnt` = 2, wait 10 cycles, resume → seconds increments 2 cycles after `enable` returns to 1, with no change while paused.
- RUNNING with `seconds` = 23: raise `start_stop_btn` and `clear_btn` in the same cycle → IDLE, `sw_clear` 1 cycle, `seconds` = 0, `enable` = 0.
- Clear edge in the cycle where `seconds` = 59 and `tick` = 1 → `seconds` = 0, `sec_rollover` never asserts, `sw_clear` = 1 for 1 cycle.
- Assert `rst` asynchronously between edges at `seconds` = 37 → all outputs 0 before the next edge; after release, state is IDLE.
